// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single BlockRam port, with a
// per-grant hold limit that forces a release and latches a sticky timeout flag.

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 10
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 8
`endif

module mem_arbiter #(
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
    parameter int HOLD_LIMIT  = 64
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   p0_read_enable,
    input  logic                   p0_write_enable,
    input  logic [MADDR_WIDTH-1:0] p0_addr,
    input  logic [MDATA_WIDTH-1:0] p0_write_data,
    output logic                   p0_read_ready,
    output logic                   p0_write_ready,
    output logic [MDATA_WIDTH-1:0] p0_read_data,

    input  logic                   p1_read_enable,
    input  logic                   p1_write_enable,
    input  logic [MADDR_WIDTH-1:0] p1_addr,
    input  logic [MDATA_WIDTH-1:0] p1_write_data,
    output logic                   p1_read_ready,
    output logic                   p1_write_ready,
    output logic [MDATA_WIDTH-1:0] p1_read_data,

    output logic                   mem_read_enable,
    output logic                   mem_write_enable,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    output logic [MDATA_WIDTH-1:0] mem_write_data,
    input  logic                   mem_read_ready,
    input  logic                   mem_write_ready,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,

    output logic [1:0]             grant,
    output logic                   hold_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int CNT_W = ($clog2(HOLD_LIMIT + 1) > 16) ? $clog2(HOLD_LIMIT + 1) : 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_LIMIT - 1);

    state_t           state_q;
    logic [1:0]       grant_q;
    logic             prio_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;

    logic req0;
    logic req1;

    assign req0 = p0_read_enable | p0_write_enable;
    assign req1 = p1_read_enable | p1_write_enable;

    // prio_q set means port 1 wins a tie; it always points away from the last grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            prio_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 && (!req1 || !prio_q)) begin
                        state_q <= GRANT0;
                        grant_q <= 2'b01;
                        prio_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else if (req1) begin
                        state_q <= GRANT1;
                        grant_q <= 2'b10;
                        prio_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                GRANT0: begin
                    if (!req0) begin
                        state_q <= RELEASE;
                        grant_q <= 2'b00;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= RELEASE;
                        grant_q   <= 2'b00;
                        timeout_q <= 1'b1;
                        prio_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GRANT1: begin
                    if (!req1) begin
                        state_q <= RELEASE;
                        grant_q <= 2'b00;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= RELEASE;
                        grant_q   <= 2'b00;
                        timeout_q <= 1'b1;
                        prio_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // A write wins over a read when a port raises both enables at once.
    always_comb begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_write_data   = '0;
        p0_read_ready    = 1'b0;
        p0_write_ready   = 1'b0;
        p0_read_data     = '0;
        p1_read_ready    = 1'b0;
        p1_write_ready   = 1'b0;
        p1_read_data     = '0;
        case (state_q)
            GRANT0: begin
                mem_write_enable = p0_write_enable;
                mem_read_enable  = p0_read_enable & ~p0_write_enable;
                mem_addr         = p0_addr;
                mem_write_data   = p0_write_data;
                p0_read_ready    = mem_read_ready;
                p0_write_ready   = mem_write_ready;
                p0_read_data     = mem_read_data;
            end
            GRANT1: begin
                mem_write_enable = p1_write_enable;
                mem_read_enable  = p1_read_enable & ~p1_write_enable;
                mem_addr         = p1_addr;
                mem_write_data   = p1_write_data;
                p1_read_ready    = mem_read_ready;
                p1_write_ready   = mem_write_ready;
                p1_read_data     = mem_read_data;
            end
            default: ;
        endcase
    end

    assign grant        = grant_q;
    assign hold_timeout = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a registered BlockRam model answers one cycle
// after each enabled cycle; inputs change and outputs are sampled on negedges.

module tb_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       p0_read_enable, p0_write_enable;
    logic [7:0] p0_addr, p0_write_data;
    logic       p0_read_ready, p0_write_ready;
    logic [7:0] p0_read_data;
    logic       p1_read_enable, p1_write_enable;
    logic [7:0] p1_addr, p1_write_data;
    logic       p1_read_ready, p1_write_ready;
    logic [7:0] p1_read_data;
    logic       mem_read_enable, mem_write_enable;
    logic [7:0] mem_addr, mem_write_data;
    logic       mem_read_ready, mem_write_ready;
    logic [7:0] mem_read_data;
    logic [1:0] grant;
    logic       hold_timeout;

    logic [7:0] memArray [256];

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(
        .MADDR_WIDTH(8),
        .MDATA_WIDTH(8),
        .HOLD_LIMIT (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .p0_read_enable  (p0_read_enable),
        .p0_write_enable (p0_write_enable),
        .p0_addr         (p0_addr),
        .p0_write_data   (p0_write_data),
        .p0_read_ready   (p0_read_ready),
        .p0_write_ready  (p0_write_ready),
        .p0_read_data    (p0_read_data),
        .p1_read_enable  (p1_read_enable),
        .p1_write_enable (p1_write_enable),
        .p1_addr         (p1_addr),
        .p1_write_data   (p1_write_data),
        .p1_read_ready   (p1_read_ready),
        .p1_write_ready  (p1_write_ready),
        .p1_read_data    (p1_read_data),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read_ready  (mem_read_ready),
        .mem_write_ready (mem_write_ready),
        .mem_read_data   (mem_read_data),
        .grant           (grant),
        .hold_timeout    (hold_timeout)
    );

    always #5 clock = ~clock;

    // BlockRam stand-in; reset preloads the word the single-read scenario expects.
    always @(posedge clock) begin
        if (reset) begin
            memArray[8'h10] <= 8'h2A;
            mem_read_ready  <= 1'b0;
            mem_write_ready <= 1'b0;
            mem_read_data   <= 8'h00;
        end else begin
            if (mem_write_enable) memArray[mem_addr] <= mem_write_data;
            if (mem_read_enable) mem_read_data <= memArray[mem_addr];
            mem_read_ready  <= mem_read_enable;
            mem_write_ready <= mem_write_enable;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_inputs();
        p0_read_enable = 0; p0_write_enable = 0; p0_addr = 0; p0_write_data = 0;
        p1_read_enable = 0; p1_write_enable = 0; p1_addr = 0; p1_write_data = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        step(1);
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step(2);
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_grant: got %b expected 00", grant);
        end
        vectors++;
        if (hold_timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_timeout: got %b expected 0", hold_timeout);
        end
        vectors++;
        if ({mem_read_enable, mem_write_enable, mem_addr, mem_write_data} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mem: got %h expected 0",
                     {mem_read_enable, mem_write_enable, mem_addr, mem_write_data});
        end
        vectors++;
        if ({p0_read_ready, p0_write_ready, p0_read_data, p1_read_ready, p1_write_ready, p1_read_data} !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_ports: got %h expected 0",
                     {p0_read_ready, p0_write_ready, p0_read_data, p1_read_ready, p1_write_ready, p1_read_data});
        end
        reset = 0;
        step(1);
    endtask

    task automatic test_single_read();
        p0_read_enable = 1; p0_addr = 8'h10;
        step(1);
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rd_grant: got %b expected 01", grant);
        end
        vectors++;
        if ({mem_read_enable, mem_write_enable, mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
            miscompares++;
            $display("[TB] FAIL rd_mem_req: got %h expected %h",
                     {mem_read_enable, mem_write_enable, mem_addr}, {1'b1, 1'b0, 8'h10});
        end
        step(1);
        vectors++;
        if ({p0_read_ready, p0_read_data} !== {1'b1, 8'h2A}) begin
            miscompares++;
            $display("[TB] FAIL rd_data: got %h expected %h", {p0_read_ready, p0_read_data}, {1'b1, 8'h2A});
        end
        vectors++;
        if ({p1_read_ready, p1_write_ready, p1_read_data} !== 10'h0) begin
            miscompares++;
            $display("[TB] FAIL rd_p1_quiet: got %h expected 0", {p1_read_ready, p1_write_ready, p1_read_data});
        end
        p0_read_enable = 0;
        step(1);
        vectors++;
        if ({grant, mem_read_enable, mem_write_enable} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rd_release: got %b expected 0000", {grant, mem_read_enable, mem_write_enable});
        end
        step(1);
    endtask

    task automatic test_round_robin();
        pulse_reset();
        p0_write_enable = 1; p0_addr = 8'h30; p0_write_data = 8'hA1;
        p1_write_enable = 1; p1_addr = 8'h31; p1_write_data = 8'hB2;
        step(1);
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rr_first: got %b expected 01", grant);
        end
        vectors++;
        if ({mem_write_enable, mem_addr, mem_write_data} !== {1'b1, 8'h30, 8'hA1}) begin
            miscompares++;
            $display("[TB] FAIL rr_first_mem: got %h expected %h",
                     {mem_write_enable, mem_addr, mem_write_data}, {1'b1, 8'h30, 8'hA1});
        end
        step(1);
        vectors++;
        if ({p0_write_ready, p1_write_ready} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rr_first_ready: got %b expected 10", {p0_write_ready, p1_write_ready});
        end
        p0_write_enable = 0;
        step(1);
        vectors++;
        if ({grant, mem_write_enable} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rr_release: got %b expected 000", {grant, mem_write_enable});
        end
        step(1);
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rr_idle: got %b expected 00", grant);
        end
        step(1);
        vectors++;
        if ({grant, mem_addr, mem_write_data} !== {2'b10, 8'h31, 8'hB2}) begin
            miscompares++;
            $display("[TB] FAIL rr_second: got %h expected %h", {grant, mem_addr, mem_write_data}, {2'b10, 8'h31, 8'hB2});
        end
        step(1);
        p1_write_enable = 0;
        step(2);
        p0_write_enable = 1; p0_addr = 8'h32;
        p1_write_enable = 1; p1_addr = 8'h33;
        step(1);
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rr_third: got %b expected 01", grant);
        end
        step(1);
        p0_write_enable = 0;
        step(3);
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rr_fourth: got %b expected 10", grant);
        end
        step(1);
        p1_write_enable = 0;
        step(2);
    endtask

    task automatic test_contention();
        p1_write_enable = 1; p1_addr = 8'h40; p1_write_data = 8'h77;
        step(1);
        p0_read_enable = 1; p0_addr = 8'h31;
        for (int i = 0; i < 3; i++) begin
            step(1);
            vectors++;
            if ({grant, p0_read_ready} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL hold_p1_cycle%0d: got %b expected 100", i, {grant, p0_read_ready});
            end
        end
        p1_write_enable = 0;
        step(1);
        vectors++;
        if ({grant, mem_read_enable, mem_write_enable} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL hold_gap: got %b expected 0000", {grant, mem_read_enable, mem_write_enable});
        end
        step(2);
        vectors++;
        if ({grant, mem_read_enable, mem_addr} !== {2'b01, 1'b1, 8'h31}) begin
            miscompares++;
            $display("[TB] FAIL hold_p0_grant: got %h expected %h", {grant, mem_read_enable, mem_addr}, {2'b01, 1'b1, 8'h31});
        end
        step(1);
        vectors++;
        if ({p0_read_ready, p0_read_data} !== {1'b1, 8'hB2}) begin
            miscompares++;
            $display("[TB] FAIL hold_p0_data: got %h expected %h", {p0_read_ready, p0_read_data}, {1'b1, 8'hB2});
        end
        p0_read_enable = 0;
        step(2);
    endtask

    task automatic test_both_enables();
        p0_read_enable = 1; p0_write_enable = 1; p0_addr = 8'h20; p0_write_data = 8'h55;
        step(1);
        vectors++;
        if ({mem_read_enable, mem_write_enable, mem_addr, mem_write_data} !== {1'b0, 1'b1, 8'h20, 8'h55}) begin
            miscompares++;
            $display("[TB] FAIL both_mem: got %h expected %h",
                     {mem_read_enable, mem_write_enable, mem_addr, mem_write_data}, {1'b0, 1'b1, 8'h20, 8'h55});
        end
        step(1);
        vectors++;
        if ({p0_write_ready, p0_read_ready} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL both_ready: got %b expected 10", {p0_write_ready, p0_read_ready});
        end
        p0_read_enable = 0; p0_write_enable = 0;
        step(2);
        p0_read_enable = 1; p0_addr = 8'h20;
        step(2);
        vectors++;
        if ({p0_read_ready, p0_read_data} !== {1'b1, 8'h55}) begin
            miscompares++;
            $display("[TB] FAIL both_readback: got %h expected %h", {p0_read_ready, p0_read_data}, {1'b1, 8'h55});
        end
        p0_read_enable = 0;
        step(2);
    endtask

    task automatic test_timeout();
        p0_read_enable = 1; p0_addr = 8'h10;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k == 1) begin
                p1_write_enable = 1; p1_addr = 8'h50; p1_write_data = 8'h66;
            end
            vectors++;
            if ({grant, hold_timeout} !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL to_hold_cycle%0d: got %b expected 010", k, {grant, hold_timeout});
            end
        end
        step(1);
        vectors++;
        if ({grant, hold_timeout, mem_read_enable} !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL to_forced_release: got %b expected 0010", {grant, hold_timeout, mem_read_enable});
        end
        step(2);
        vectors++;
        if ({grant, mem_write_enable, mem_addr} !== {2'b10, 1'b1, 8'h50}) begin
            miscompares++;
            $display("[TB] FAIL to_p1_next: got %h expected %h", {grant, mem_write_enable, mem_addr}, {2'b10, 1'b1, 8'h50});
        end
        step(1);
        p1_write_enable = 0;
        step(3);
        vectors++;
        if ({grant, hold_timeout} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL to_p0_rerequest: got %b expected 011", {grant, hold_timeout});
        end
        p0_read_enable = 0;
        step(2);
        vectors++;
        if (hold_timeout !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_sticky: got %b expected 1", hold_timeout);
        end
    endtask

    task automatic test_reset_mid_write();
        p1_write_enable = 1; p1_addr = 8'h60; p1_write_data = 8'h11;
        step(1);
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_grant: got %b expected 10", grant);
        end
        reset = 1;
        step(1);
        vectors++;
        if ({grant, mem_write_enable, hold_timeout, p1_write_ready} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_clear: got %b expected 00000",
                     {grant, mem_write_enable, hold_timeout, p1_write_ready});
        end
        reset = 0;
        p0_write_enable = 1; p0_addr = 8'h61; p0_write_data = 8'h22;
        step(1);
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_prio: got %b expected 01", grant);
        end
        clear_inputs();
        step(2);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_contention();
        test_both_enables();
        test_timeout();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
